bcd_to_bin_seq: RTL and testbench



---
 rtl/bcd_to_bin_seq_pkg.sv | 19 +
 rtl/bcd_nib_adj.sv | 9 +
 rtl/bcd_to_bin_seq.sv | 104 ++++++++++
 tb/tb_bcd_to_bin_seq.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/bcd_to_bin_seq_pkg.sv
// rtl/bcd_to_bin_seq_pkg.sv - shared types and constants for the BCD-to-binary converter
package bcd_to_bin_seq_pkg;

  localparam int N_DIG_DEF = 4;
  localparam int BIN_W_DEF = 14;

  localparam logic [3:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ERR   = 2'd2
  } state_t;

  function automatic logic digit_bad(input logic [3:0] d);
    return d > BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_nib_adj.sv
// rtl/bcd_nib_adj.sv - reverse double-dabble nibble correction (subtract 3 when >= 8)
module bcd_nib_adj (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  assign nib_o = (nib_i >= 4'd8) ? (nib_i - 4'd3) : nib_i;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - sequential 4-digit BCD to binary converter (reverse double-dabble)
module bcd_to_bin_seq
  import bcd_to_bin_seq_pkg::*;
#(
  parameter int N_DIG = N_DIG_DEF,
  parameter int BIN_W = BIN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       dig4,
  input  logic [3:0]       dig3,
  input  logic [3:0]       dig2,
  input  logic [3:0]       dig1,
  output logic [BIN_W-1:0] binary,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int BCD_W = 4 * N_DIG;
  localparam int CNT_W = $clog2(BIN_W) + 1;

  state_t           state_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BIN_W-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [BIN_W-1:0] binary_q;
  logic             done_q;
  logic             err_q;

  logic [BCD_W-1:0] bcd_shift;
  logic [BCD_W-1:0] bcd_d;
  logic [BIN_W-1:0] acc_d;
  logic [CNT_W-1:0] cnt_d;
  logic [BCD_W-1:0] digits;
  logic             any_bad;

  assign digits  = {dig4, dig3, dig2, dig1};
  assign any_bad = digit_bad(dig4) | digit_bad(dig3) | digit_bad(dig2) | digit_bad(dig1);

  // The bcd LSB falls into the acc MSB; correction is applied to the shifted value.
  assign {bcd_shift, acc_d} = {bcd_q, acc_q} >> 1;
  assign cnt_d = cnt_q - CNT_W'(1);

  for (genvar g = 0; g < N_DIG; g++) begin : g_adj
    bcd_nib_adj u_adj (
      .nib_i(bcd_shift[4*g +: 4]),
      .nib_o(bcd_d[4*g +: 4])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      bcd_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      binary_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (any_bad) begin
              state_q <= ST_ERR;
            end else begin
              state_q <= ST_SHIFT;
              bcd_q   <= digits;
              acc_q   <= '0;
              cnt_q   <= CNT_W'(BIN_W);
            end
          end
        end
        ST_SHIFT: begin
          bcd_q <= bcd_d;
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          if (cnt_d == '0) begin
            state_q  <= ST_IDLE;
            binary_q <= acc_d;
            err_q    <= 1'b0;
            done_q   <= 1'b1;
          end
        end
        ST_ERR: begin
          state_q  <= ST_IDLE;
          binary_q <= '0;
          err_q    <= 1'b1;
          done_q   <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign binary = binary_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb/tb_bcd_to_bin_seq.sv - scoreboard bench for bcd_to_bin_seq
module tb_bcd_to_bin_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  dig4, dig3, dig2, dig1;
  logic [13:0] binary;
  logic        busy, done, err;

  typedef struct {
    logic [13:0] bin;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  bcd_to_bin_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dig4(dig4), .dig3(dig3), .dig2(dig2), .dig1(dig1),
    .binary(binary), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("binary", int'(binary), int'(e.bin));
        chk("err", int'(err), int'(e.err));
        chk("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Called at a negedge; start is sampled at the next posedge.
  task automatic issue(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] d, input logic [13:0] eb, input logic ee,
                       input logic push);
    dig4 = a; dig3 = b; dig2 = c; dig1 = d;
    start = 1'b1;
    if (push) exp_q.push_back('{eb, ee, cyc + 1 + (ee ? 1 : 14)});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    dig4 = 4'd0; dig3 = 4'd0; dig2 = 4'd0; dig1 = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_binary", int'(binary), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(4'd9, 4'd9, 4'd9, 4'd9, 14'h270F, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) begin
      chk("busy_during", int'(busy), 1);
      @(negedge clk);
    end
    chk("busy_after", int'(busy), 0);
    chk("done_at_14", int'(done), 1);

    @(negedge clk);
    issue(4'd0, 4'd0, 4'd0, 4'd0, 14'd0, 1'b0, 1'b1);
    wait_done();
    @(negedge clk);
    issue(4'd1, 4'd2, 4'd3, 4'd4, 14'h04D2, 1'b0, 1'b1);
    wait_done();
    @(negedge clk);
    issue(4'd0, 4'd0, 4'd0, 4'd1, 14'd1, 1'b0, 1'b1);
    wait_done();
    @(negedge clk);
    issue(4'd1, 4'hA, 4'd3, 4'd4, 14'd0, 1'b1, 1'b1);
    wait_done();
    @(negedge clk);
    issue(4'd0, 4'd0, 4'd4, 4'd2, 14'd42, 1'b0, 1'b1);
    wait_done();

    // A second start while busy must be ignored, and digit changes must not leak in.
    @(negedge clk);
    issue(4'd5, 4'd6, 4'd7, 4'd8, 14'd5678, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    issue(4'd9, 4'd9, 4'd9, 4'd9, 14'd0, 1'b0, 1'b0);
    wait_done();
    issue(4'd0, 4'd5, 4'd0, 4'd0, 14'd500, 1'b0, 1'b1);
    wait_done();
    repeat (5) @(negedge clk);

    @(negedge clk);
    issue(4'd1, 4'd2, 4'd3, 4'd4, 14'd0, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_binary", int'(binary), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_err", int'(err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_after_rst", int'(busy), 0);

    issue(4'd9, 4'd8, 4'd7, 4'd6, 14'd9876, 1'b0, 1'b1);
    wait_done();
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
